// File: rtl/index_sequencer.sv
// -----------------------------------------------------------------------------
// index_sequencer
//
// Generates the 3-bit select that feeds the 3-to-8 one-hot decoder. Two
// push-buttons are synchronized and edge-detected. One button steps the index
// by hand and the other cycles through four modes:
// MANUAL -> UP -> DOWN -> PONG -> MANUAL.
// In the automatic modes the index steps once per prescaler period while en
// is high.
//
// Parameters
//   DIV       prescaler period in clock cycles between automatic steps
//             (1..65535)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   en        run enable for UP/DOWN/PONG (synchronous level)
//   btn_next  asynchronous button, rising edge = one step in MANUAL
//   btn_mode  asynchronous button, rising edge = advance to the next mode
//   sel       registered index for the decoder
//   mode      registered mode: 00 MANUAL, 01 UP, 10 DOWN, 11 PONG
//   step      registered one-cycle pulse that accompanies each new sel value
// -----------------------------------------------------------------------------
module index_sequencer #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       btn_next,
   input  logic       btn_mode,
   output logic [2:0] sel,
   output logic [1:0] mode,
   output logic       step
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_PONG   = 2'b11
   } mode_t;

   logic          next_s1, next_s2, next_s3;
   logic          mode_s1, mode_s2, mode_s3;
   logic          next_rise, mode_rise;

   mode_t         state_q, state_d;
   logic [2:0]    sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_up_q, dir_up_d;
   logic          step_d;

   // Each button passes through a two-flop synchronizer (s1, s2). A third
   // history flop (s3) then turns a held level into a single rise. All three
   // flops clear on reset. A button that is held through reset therefore
   // produces exactly one rise once reset drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_s1 <= 1'b0;
         next_s2 <= 1'b0;
         next_s3 <= 1'b0;
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
         mode_s3 <= 1'b0;
      end else begin
         next_s1 <= btn_next;
         next_s2 <= next_s1;
         next_s3 <= next_s2;
         mode_s1 <= btn_mode;
         mode_s2 <= mode_s1;
         mode_s3 <= mode_s2;
      end
   end

   assign next_rise = next_s2 & ~next_s3;
   assign mode_rise = mode_s2 & ~mode_s3;

   // Next-state logic. A mode rise has priority over everything else. In a
   // mode-change cycle the index holds, no step is produced, the prescaler
   // restarts from zero and the pong direction is reset to up. Otherwise
   // MANUAL steps only on a btn_next rise. The automatic modes run the
   // prescaler while en is high and step when the count reaches DIV-1.
   // PONG turns around at either end without repeating the end value.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel;
      cnt_d    = cnt_q;
      dir_up_d = dir_up_q;
      step_d   = 1'b0;

      if (mode_rise) begin
         case (state_q)
            MODE_MANUAL: state_d = MODE_UP;
            MODE_UP:     state_d = MODE_DOWN;
            MODE_DOWN:   state_d = MODE_PONG;
            default:     state_d = MODE_MANUAL;
         endcase
         cnt_d    = '0;
         dir_up_d = 1'b1;
      end else if (state_q == MODE_MANUAL) begin
         cnt_d = '0;
         if (next_rise) begin
            sel_d  = sel + 3'd1;
            step_d = 1'b1;
         end
      end else if (!en) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d  = '0;
         step_d = 1'b1;
         case (state_q)
            MODE_UP:   sel_d = sel + 3'd1;
            MODE_DOWN: sel_d = sel - 3'd1;
            default: begin
               if (dir_up_q) begin
                  if (sel == 3'd7) begin
                     dir_up_d = 1'b0;
                     sel_d    = 3'd6;
                  end else begin
                     sel_d = sel + 3'd1;
                  end
               end else begin
                  if (sel == 3'd0) begin
                     dir_up_d = 1'b1;
                     sel_d    = 3'd1;
                  end else begin
                     sel_d = sel - 3'd1;
                  end
               end
            end
         endcase
      end
   end

   // State, index, prescaler, direction and the step pulse all register
   // together. The outputs therefore have no combinational path from any
   // input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= MODE_MANUAL;
         sel      <= 3'd0;
         cnt_q    <= '0;
         dir_up_q <= 1'b1;
         step     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel      <= sel_d;
         cnt_q    <= cnt_d;
         dir_up_q <= dir_up_d;
         step     <= step_d;
      end
   end

   assign mode = state_q;

endmodule

// File: doc/index_sequencer.md
# index_sequencer

Sequential index generator that sits directly upstream of the 3-to-8 one-hot decoder. It produces the 3-bit select `sel` that the decoder expands into eight output lines. The block synchronizes and edge-detects two push-button inputs, runs a mode state machine (manual, count up, count down, ping-pong), and steps the index from a programmable prescaler tick.

## Interface
- `DIV`, default 4: prescaler period in clock cycles between automatic steps; legal range 1..65535; counter width is max(1, $clog2(DIV)).
- `clk`  in  1  system clock; all flops trigger on the rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of `clk`.
- `en`  in  1  run enable for the automatic modes; level-sensitive, already synchronous to `clk`.
- `btn_next`  in  1  asynchronous button; its rising edge requests one step in MANUAL.
- `btn_mode`  in  1  asynchronous button; its rising edge advances the mode.
- `sel`  out  3  index to the decoder's `input_bits`.
- `mode`  out  2  current mode: 00 MANUAL, 01 UP, 10 DOWN, 11 PONG.
- `step`  out  1  one-cycle pulse, high in the cycle in which `sel` shows a newly stepped value.

## Operation
- Input conditioning, per button:
  - two-flop synchronizer (`s1`, `s2`) plus a history flop `s3`;
  - `rise = s2 & ~s3`.
- Mode FSM states, advanced on `btn_mode` rise: MANUAL → UP → DOWN → PONG → MANUAL.
- On every mode transition:
  - prescaler is cleared to 0;
  - pong direction is set to up;
  - `sel` is held.
- MANUAL:
  - `btn_next` rise gives `sel <= sel+1` (mod 8);
  - prescaler is idle at 0;
  - `en` is ignored.
- UP: on each tick, `sel <= sel+1` mod 8, so 7 → 0.
- DOWN: on each tick, `sel <= sel-1` mod 8, so 0 → 7.
- PONG:
  - on each tick, step in the current direction;
  - when `sel` is 7 while going up, the direction flips and the step goes to 6;
  - when `sel` is 0 while going down, the direction flips and the step goes to 1;
  - no value repeats at the ends; sequence from 0 is 0,1,…,7,6,…,0,1,….
- In the automatic modes, `btn_next` is ignored.
- Prescaler, in UP/DOWN/PONG with `en`=1:
  - increments every cycle;
  - tick when count == DIV-1, at which point count returns to 0 and a step occurs;
  - DIV=1 steps every enabled cycle.
- With `en`=0: prescaler is cleared to 0, `sel` holds, and `step`=0.
- Simultaneous events:
  - `btn_mode` rise in the same cycle as a tick or a `btn_next` rise: the mode change wins and no step occurs that cycle;
  - `btn_next` and `btn_mode` rising together in MANUAL: only the mode advances.
- Reset values:
  - `sel`=0, `mode`=00, `step`=0;
  - direction up, prescaler 0;
  - all synchronizer and history flops 0.
- Reset mid-operation: overrides every other input in that cycle and restores the reset values.
- A button held high through reset registers exactly one rise after `rst` falls.

## Timing
- Button to `sel` latency:
  - the input is high at rising edge E0;
  - `s1`=1 after E0 and `s2`=1 after E1;
  - `rise` is high between E1 and E2;
  - the new `sel`/`mode` is registered at E2 and is visible after E2.
- A button pulse must be high across at least one rising edge to be detected.
- Holding a button produces exactly one action; release followed by re-press is required for another.
- First automatic step: the mode register enters UP/DOWN/PONG at edge M, and the first step is registered at edge M+DIV with `en`=1 throughout.
- Subsequent automatic steps occur every DIV cycles.
- `en` falling: takes effect at the next edge, with no step at that edge.
- `en` rising: counting restarts from 0, and the next step occurs DIV edges later.
- `step` is registered together with `sel` and is high for exactly one cycle per step, never in a mode-change cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst` for 2 cycles with random inputs → `sel`=0, `mode`=00, `step`=0; after release, no activity while the buttons are low.
- MANUAL wrap: 9 separate `btn_next` presses → `sel` goes 1,2,…,7,0,1, each change 3 edges after the press, with `step` pulsed once per press; holding the button for 20 cycles gives a single step.
- UP with DIV=4, `en`=1: one `btn_mode` press → `mode`=01, then `sel` increments every 4 cycles with 7 → 0 wrap; drop `en` for 10 cycles → `sel` frozen, then resumes 4 cycles after `en` rises.
- DOWN and PONG:
  - from `sel`=2, DOWN gives 1,0,7;
  - PONG started at `sel`=5 gives 6,7,6,5,4,3,2,1,0,1 with no repeated endpoint.
- Collision: assert a `btn_mode` rise in the same cycle as a prescaler tick in UP → `mode` becomes 10, `sel` unchanged, `step`=0, and the next step occurs DIV cycles later going down.
- Reset mid-PONG while descending at `sel`=4 with `btn_mode` held high → after reset, `sel`=0 and `mode`=00, then exactly one mode advance to 01 from the held button.
